// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and PC constants for the fetch sequencer.
package pc_seq_pkg;
   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] DEF_PC_STEP = 32'd4;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: ID/hazard/imem handshake bundle around the fetch sequencer.
interface pc_sequencer_if;
   import pc_seq_pkg::*;
   logic            start;
   logic            branch;
   logic            equal;
   logic [PC_W-1:0] branch_addr;
   logic            jump;
   logic [PC_W-1:0] jump_addr;
   logic            hazard_stall;
   logic            imem_ack;
   logic            imem_req;
   logic [PC_W-1:0] pc;
   logic            ifid_write;
   logic            ifid_flush;
   modport master (
      output start, branch, equal, branch_addr, jump, jump_addr, hazard_stall, imem_ack,
      input  imem_req, pc, ifid_write, ifid_flush
   );
   modport slave (
      input  start, branch, equal, branch_addr, jump, jump_addr, hazard_stall, imem_ack,
      output imem_req, pc, ifid_write, ifid_flush
   );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority select of next PC and IF/ID controls
// (stall > pending redirect > live redirect > sequential).
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter logic [PC_W-1:0] STEP = DEF_PC_STEP
) (
   input  logic            i_stall,
   input  logic            i_ack,
   input  logic            i_pend_valid,
   input  logic [PC_W-1:0] i_pend_target,
   input  logic            i_live_redir,
   input  logic [PC_W-1:0] i_live_target,
   input  logic [PC_W-1:0] i_pc,
   output logic [PC_W-1:0] o_next_pc,
   output logic            o_write,
   output logic            o_flush,
   output logic            o_apply,
   output logic            o_latch
);
   assign o_apply   = ~i_stall & i_ack & (i_pend_valid | i_live_redir);
   assign o_latch   = ~i_stall & ~i_ack & i_live_redir;
   assign o_write   = ~i_stall;
   // a missing instruction is a bubble; a redirect squashes the wrong-path one
   assign o_flush   = ~i_stall & (~i_ack | o_apply);
   assign o_next_pc = (i_stall | ~i_ack) ? i_pc :
                      i_pend_valid       ? i_pend_target :
                      i_live_redir       ? i_live_target : i_pc + STEP;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: IF-stage PC owner sequencing redirects, load-use stalls and imem wait states.
// Define PC_SEQ_STAT_EN to add redirect_cnt_o / wait_cnt_o statistics counters.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [PC_W-1:0] PC_STEP  = DEF_PC_STEP
) (
   input  logic          clk_i,
   input  logic          rst_i,
   pc_sequencer_if.slave bus
`ifdef PC_SEQ_STAT_EN
   ,
   output logic [31:0]   redirect_cnt_o,
   output logic [31:0]   wait_cnt_o
`endif
);
   state_t          r_state, w_state_nxt;
   logic [PC_W-1:0] r_pc, r_pend_target, w_next_pc, w_live_target;
   logic            r_pend_valid, w_active, w_live_redir;
   logic            w_write, w_flush, w_apply, w_latch;

   assign w_active      = (r_state != IDLE);
   assign w_live_redir  = bus.jump | (bus.branch & bus.equal);
   assign w_live_target = bus.jump ? bus.jump_addr : bus.branch_addr;

   pc_next_sel #(.STEP(PC_STEP)) u_sel (
      .i_stall       (bus.hazard_stall),
      .i_ack         (bus.imem_ack),
      .i_pend_valid  (r_pend_valid),
      .i_pend_target (r_pend_target),
      .i_live_redir  (w_live_redir),
      .i_live_target (w_live_target),
      .i_pc          (r_pc),
      .o_next_pc     (w_next_pc),
      .o_write       (w_write),
      .o_flush       (w_flush),
      .o_apply       (w_apply),
      .o_latch       (w_latch)
   );

   // a stall keeps the state, but an ack during WAIT_ACK still ends the wait
   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = (r_state == IDLE)     ? (bus.start ? RUN : IDLE) :
                    (r_state == RUN)      ? ((bus.hazard_stall | bus.imem_ack) ? RUN : WAIT_ACK) :
                    (r_state == WAIT_ACK) ? (bus.imem_ack ? RUN : WAIT_ACK) : IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= IDLE;
         r_pc          <= RESET_PC;
         r_pend_valid  <= 1'b0;
         r_pend_target <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_active) begin
            r_pc <= w_next_pc;
            if (w_apply) r_pend_valid <= 1'b0;
            else if (w_latch) begin
               r_pend_valid  <= 1'b1;
               r_pend_target <= w_live_target;
            end
         end
      end
   end

   assign bus.imem_req   = w_active;
   assign bus.pc         = r_pc;
   assign bus.ifid_write = w_active & w_write;
   assign bus.ifid_flush = w_active & w_flush;

`ifdef PC_SEQ_STAT_EN
   logic [31:0] r_redirect_cnt, r_wait_cnt;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_redirect_cnt <= '0;
         r_wait_cnt     <= '0;
      end else begin
         if (w_active & w_apply) r_redirect_cnt <= r_redirect_cnt + 32'd1;
         if (r_state == WAIT_ACK) r_wait_cnt <= r_wait_cnt + 32'd1;
      end
   end
   assign redirect_cnt_o = r_redirect_cnt;
   assign wait_cnt_o     = r_wait_cnt;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run against a queue-based fetch model.
module tb_pc_sequencer;
   import pc_seq_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_err = 0;

   pc_sequencer_if bus ();
   pc_sequencer_if bw ();
`ifdef PC_SEQ_STAT_EN
   logic [31:0] rcnt, wcnt, rcnt_w, wcnt_w;
`endif

   pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i (clk), .rst_i (rst), .bus (bus)
`ifdef PC_SEQ_STAT_EN
      , .redirect_cnt_o (rcnt), .wait_cnt_o (wcnt)
`endif
   );
   pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk_i (clk), .rst_i (rst), .bus (bw)
`ifdef PC_SEQ_STAT_EN
      , .redirect_cnt_o (rcnt_w), .wait_cnt_o (wcnt_w)
`endif
   );

   logic [34:0] obs, obs_w;
   assign obs   = {bus.imem_req, bus.ifid_write, bus.ifid_flush, bus.pc};
   assign obs_w = {bw.imem_req, bw.ifid_write, bw.ifid_flush, bw.pc};

   function automatic logic [34:0] ex(logic r, logic w, logic f, logic [31:0] p);
      return {r, w, f, p};
   endfunction

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.start = 0; bus.branch = 0; bus.equal = 0; bus.branch_addr = '0;
      bus.jump = 0; bus.jump_addr = '0; bus.hazard_stall = 0; bus.imem_ack = 1;
      bw.start = 0; bw.branch = 0; bw.equal = 0; bw.branch_addr = '0;
      bw.jump = 0; bw.jump_addr = '0; bw.hazard_stall = 0; bw.imem_ack = 1;
   endtask

   task automatic restart();
      clr();
      rst = 1;
      adv();
      rst = 0;
      bus.start = 1; bw.start = 1;
      adv();
      bus.start = 0; bw.start = 0;
   endtask

   task automatic test_reset();
      clr();
      adv(); adv();
      @(negedge clk); n_cmp++;
      if (obs !== ex(0, 0, 0, 32'h0)) begin n_err++; $display("FAIL reset_state got %h want %h", obs, ex(0, 0, 0, 32'h0)); end
      n_cmp++;
      if (obs_w !== ex(0, 0, 0, 32'hFFFF_FFF8)) begin n_err++; $display("FAIL reset_state_w got %h want %h", obs_w, ex(0, 0, 0, 32'hFFFF_FFF8)); end
`ifdef PC_SEQ_STAT_EN
      n_cmp++;
      if ({rcnt, wcnt} !== 64'h0) begin n_err++; $display("FAIL reset_cnt got %h want 0", {rcnt, wcnt}); end
`endif
   endtask

   task automatic test_sequential();
      restart();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); n_cmp++;
         if (obs !== ex(1, 1, 0, 32'(4 * i))) begin n_err++; $display("FAIL seq_%0d got %h want %h", i, obs, ex(1, 1, 0, 32'(4 * i))); end
         adv();
      end
   endtask

   task automatic test_branch();
      restart(); adv(); adv();
      bus.branch = 1; bus.equal = 1; bus.branch_addr = 32'h40;
      @(negedge clk); n_cmp++;
      if (obs !== ex(1, 1, 1, 32'h8)) begin n_err++; $display("FAIL br_taken_flush got %h want %h", obs, ex(1, 1, 1, 32'h8)); end
      adv(); clr();
      @(negedge clk); n_cmp++;
      if (obs !== ex(1, 1, 0, 32'h40)) begin n_err++; $display("FAIL br_taken_pc got %h want %h", obs, ex(1, 1, 0, 32'h40)); end
      restart(); adv(); adv();
      bus.branch = 1; bus.equal = 0; bus.branch_addr = 32'h40;
      @(negedge clk); n_cmp++;
      if (obs !== ex(1, 1, 0, 32'h8)) begin n_err++; $display("FAIL br_not_taken got %h want %h", obs, ex(1, 1, 0, 32'h8)); end
      adv(); clr();
      @(negedge clk); n_cmp++;
      if (obs !== ex(1, 1, 0, 32'hC)) begin n_err++; $display("FAIL br_not_taken_pc got %h want %h", obs, ex(1, 1, 0, 32'hC)); end
   endtask

   task automatic test_wait();
      restart();
      for (int i = 0; i < 4; i++) adv();
      bus.imem_ack = 0; bus.jump = 1; bus.jump_addr = 32'h100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); n_cmp++;
         if (obs !== ex(1, 1, 1, 32'h10)) begin n_err++; $display("FAIL wait_bubble_%0d got %h want %h", i, obs, ex(1, 1, 1, 32'h10)); end
         adv();
         bus.jump = 0;
      end
      bus.imem_ack = 1;
      @(negedge clk); n_cmp++;
      if (obs !== ex(1, 1, 1, 32'h10)) begin n_err++; $display("FAIL wait_ack_flush got %h want %h", obs, ex(1, 1, 1, 32'h10)); end
      adv();
      @(negedge clk); n_cmp++;
      if (obs !== ex(1, 1, 0, 32'h100)) begin n_err++; $display("FAIL wait_pend_pc got %h want %h", obs, ex(1, 1, 0, 32'h100)); end
`ifdef PC_SEQ_STAT_EN
      n_cmp++;
      if (rcnt !== 32'd1) begin n_err++; $display("FAIL wait_redirect_cnt got %0d want 1", rcnt); end
      n_cmp++;
      if (wcnt !== 32'd3) begin n_err++; $display("FAIL wait_wait_cnt got %0d want 3", wcnt); end
`endif
   endtask

   task automatic test_stall();
      restart();
      for (int i = 0; i < 5; i++) adv();
      bus.hazard_stall = 1; bus.jump = 1; bus.jump_addr = 32'h200;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); n_cmp++;
         if (obs !== ex(1, 0, 0, 32'd20)) begin n_err++; $display("FAIL stall_hold_%0d got %h want %h", i, obs, ex(1, 0, 0, 32'd20)); end
         adv();
      end
      bus.hazard_stall = 0;
      @(negedge clk); n_cmp++;
      if (obs !== ex(1, 1, 1, 32'd20)) begin n_err++; $display("FAIL stall_release got %h want %h", obs, ex(1, 1, 1, 32'd20)); end
      adv(); clr();
      @(negedge clk); n_cmp++;
      if (obs !== ex(1, 1, 0, 32'h200)) begin n_err++; $display("FAIL stall_jump_pc got %h want %h", obs, ex(1, 1, 0, 32'h200)); end
   endtask

   task automatic test_wrap();
      logic [31:0] want;
      restart();
      want = 32'hFFFF_FFF8;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); n_cmp++;
         if (obs_w !== ex(1, 1, 0, want)) begin n_err++; $display("FAIL wrap_%0d got %h want %h", i, obs_w, ex(1, 1, 0, want)); end
         adv();
         want = want + 32'd4;
      end
   endtask

   task automatic test_reset_mid();
      restart();
      bus.imem_ack = 0; bus.jump = 1; bus.jump_addr = 32'h300;
      adv();
      bus.jump = 0; rst = 1;
      adv();
      @(negedge clk); n_cmp++;
      if (obs !== ex(0, 0, 0, 32'h0)) begin n_err++; $display("FAIL rstmid_idle got %h want %h", obs, ex(0, 0, 0, 32'h0)); end
`ifdef PC_SEQ_STAT_EN
      n_cmp++;
      if ({rcnt, wcnt} !== 64'h0) begin n_err++; $display("FAIL rstmid_cnt got %h want 0", {rcnt, wcnt}); end
`endif
      rst = 0; bus.imem_ack = 1; bus.start = 1;
      adv();
      bus.start = 0;
      @(negedge clk); n_cmp++;
      if (obs !== ex(1, 1, 0, 32'h0)) begin n_err++; $display("FAIL rstmid_restart got %h want %h", obs, ex(1, 1, 0, 32'h0)); end
      adv();
      @(negedge clk); n_cmp++;
      if (obs !== ex(1, 1, 0, 32'h4)) begin n_err++; $display("FAIL rstmid_no_pend got %h want %h", obs, ex(1, 1, 0, 32'h4)); end
   endtask

   // model: running/waiting flags, a one-deep queue of pending targets, plain PC arithmetic
   task automatic test_random();
      bit running, waiting, nrun, nwait, ew, ef, applied, redir;
      logic [31:0] mpc, npc, tgt;
      logic [31:0] pend[$];
      int unsigned mrc, mwc;
      restart();
      running = 1; waiting = 0; mpc = 32'h0; mrc = 0; mwc = 0;
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) < 2);
         bus.start = 1'($urandom_range(0, 1));
         bus.hazard_stall = ($urandom_range(0, 99) < 20);
         bus.imem_ack = ($urandom_range(0, 99) < 65);
         bus.branch = 1'($urandom_range(0, 1));
         bus.equal = 1'($urandom_range(0, 1));
         bus.jump = ($urandom_range(0, 99) < 20);
         bus.branch_addr = $urandom;
         bus.jump_addr = $urandom;
         redir = bus.jump | (bus.branch & bus.equal);
         tgt = bus.jump ? bus.jump_addr : bus.branch_addr;
         ew = 0; ef = 0; applied = 0; npc = mpc; nrun = running; nwait = waiting;
         if (!running) nrun = bus.start;
         else if (bus.hazard_stall) begin
            if (waiting && bus.imem_ack) nwait = 0;
         end else if (!bus.imem_ack) begin
            ew = 1; ef = 1; nwait = 1;
            if (redir) begin pend.delete(); pend.push_back(tgt); end
         end else begin
            ew = 1; nwait = 0;
            if (pend.size() > 0) begin npc = pend.pop_front(); ef = 1; applied = 1; end
            else if (redir) begin npc = tgt; ef = 1; applied = 1; end
            else npc = mpc + 32'd4;
         end
         @(negedge clk); n_cmp++;
         if (obs !== ex(running, ew, ef, mpc)) begin n_err++; $display("FAIL rand_%0d got %h want %h", i, obs, ex(running, ew, ef, mpc)); end
`ifdef PC_SEQ_STAT_EN
         n_cmp++;
         if ({rcnt, wcnt} !== {mrc, mwc}) begin n_err++; $display("FAIL rand_cnt_%0d got %h want %h", i, {rcnt, wcnt}, {mrc, mwc}); end
`endif
         if (rst) begin
            running = 0; waiting = 0; mpc = 32'h0; pend.delete(); mrc = 0; mwc = 0;
         end else begin
            mwc += 32'(waiting); mrc += 32'(applied);
            running = nrun; waiting = nwait; mpc = npc;
         end
         adv();
      end
      rst = 0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_wait();
      test_stall();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter and sequences the two-way PC select (taken-branch target vs. sequential address) together with jumps, load-use stalls and instruction-memory wait states. Sits in the IF stage between the ID-stage branch/compare logic, the hazard detection unit and the instruction memory/cache. Drives IF/ID write/flush so wrong-path or missing instructions never enter ID. Redirects arriving while a fetch is outstanding are latched and applied when the fetch completes.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded by reset
- PC_STEP, 4, sequential increment in bytes
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  leave IDLE and begin fetching
- branch_i  in  1  ID instruction is a conditional branch
- equal_i  in  1  ID compare result; branch taken = branch_i & equal_i
- branch_addr_i  in  32  taken-branch target
- jump_i  in  1  ID instruction is an unconditional jump
- jump_addr_i  in  32  jump target
- hazard_stall_i  in  1  load-use stall from hazard unit
- imem_ack_i  in  1  instruction for pc_o returned this cycle
- imem_req_o  out  1  fetch request for pc_o
- pc_o  out  32  current fetch address (registered)
- ifid_write_o  out  1  IF/ID register update enable
- ifid_flush_o  out  1  force IF/ID to NOP when written

## Operation
- States: IDLE, RUN, WAIT_ACK. Reset: IDLE, pc_o=RESET_PC, pend_valid=0; imem_req_o=0, ifid_write_o=0, ifid_flush_o=0.
- IDLE: outputs 0; start_i=1 -> RUN. imem_req_o=1 in RUN and WAIT_ACK.
- Redirect = jump_i | (branch_i & equal_i); target = jump_i ? jump_addr_i : branch_addr_i (jump wins if both).
- Priority in RUN/WAIT_ACK: hazard_stall_i > pending redirect > live redirect > sequential.
- hazard_stall_i=1: pc_o held, ifid_write_o=0, flush=0, live redirect ignored (re-asserted by producer after stall); state unchanged except WAIT_ACK with ack -> RUN (instruction re-fetched).
- RUN, ack=1, no stall: redirect -> pc_o<=target, write=1, flush=1; else pc_o<=pc_o+PC_STEP, write=1, flush=0.
- RUN, ack=0: -> WAIT_ACK, pc_o held, write=1, flush=1 (bubble); live redirect latched into pend_target, pend_valid<=1.
- WAIT_ACK, ack=0: hold pc_o, bubble; live redirect overwrites pend_target.
- WAIT_ACK, ack=1: pend_valid -> pc_o<=pend_target, flush=1, pend_valid<=0 (live redirect ignored: wrong path); else live redirect -> target, flush=1; else pc_o+PC_STEP, flush=0; -> RUN.
- pc_o arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Target bits used as given, no alignment check.

## Timing
- start_i sampled at edge N -> imem_req_o=1 from cycle N+1 with pc_o=RESET_PC.
- Redirect sampled at edge with ack -> pc_o=target next cycle; flush same cycle as redirect.
- Zero-wait fetch: one instruction per cycle.
- ifid_write_o/ifid_flush_o combinational from state, ack, stall, redirect; pc_o and state registered.
- rst_i mid-operation: next edge returns to IDLE, pending redirect and counters cleared, regardless of ack.

## Configuration
- PC_SEQ_STAT_EN defined: adds outputs redirect_cnt_o[31:0] (redirects applied to pc_o, live or pending) and wait_cnt_o[31:0] (cycles in WAIT_ACK); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package pc_seq_pkg: state encoding (IDLE=2'd0, RUN=2'd1, WAIT_ACK=2'd2), PC width constant 32, default PC_STEP.
- One sub-module pc_next_sel: combinational priority select of next pc and flush from stall/pending/live/sequential inputs; FSM, pc and pending register stay in top.

## Test plan
- Reset, start_i pulse, ack always 1 -> pc_o 0,4,8,12 on consecutive cycles, flush=0.
- At pc_o=8 assert branch_i=1, equal_i=1, branch_addr_i=32'h40 -> flush=1 that cycle, pc_o=32'h40 next; equal_i=0 instead -> pc_o=12.
- At pc_o=16 ack=0 for 3 cycles, jump_i=1 target 32'h100 in first wait cycle only -> 3 bubbles, on ack flush=1, pc_o=32'h100.
- hazard_stall_i=1 two cycles with jump_i asserted at pc_o=20 -> pc_o holds 20, ifid_write_o=0, no redirect; stall drops, jump held -> pc_o=jump target.
- RESET_PC=32'hFFFF_FFF8, ack=1 -> pc_o FFFF_FFF8, FFFF_FFFC, 0.
- rst_i during WAIT_ACK with pending redirect -> next cycle IDLE, pc_o=RESET_PC, imem_req_o=0; with PC_SEQ_STAT_EN counters read 0.
